// File: rtl/polar_dec_pkg.sv
// rtl/polar_dec_pkg.sv - shared polar decoder types, defaults and beat-count helper
package polar_dec_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 10;
    localparam int BEAT_W         = 16;

    typedef enum logic {
        OP_F = 1'b0,
        OP_G = 1'b1
    } op_e;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } sched_state_e;

    // Index of the final beat: a node narrower than the lane array still takes one beat.
    function automatic logic [BEAT_W-1:0] last_beat_idx(input logic [3:0] log_pairs, input int log_p);
        if (int'(log_pairs) <= log_p) begin
            return '0;
        end
        return (BEAT_W'(1) << (int'(log_pairs) - log_p)) - BEAT_W'(1);
    endfunction

endpackage

// File: rtl/llr_fg_sched_if.sv
// rtl/llr_fg_sched_if.sv - command, memory and PE-lane bundle; perf ports under LLR_FG_SCHED_PERF_CNT_EN
interface llr_fg_sched_if
    import polar_dec_pkg::*;
#(
    parameter int P          = 4,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);
    logic                  start;
    logic                  op_g;
    logic [3:0]            node_log_pairs;
    logic [ADDR_WIDTH-1:0] rd_base;
    logic [ADDR_WIDTH-1:0] wr_base;
    logic                  stall;

    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  pe_valid;
    logic                  pe_op_g;
    logic [P-1:0]          pe_lane_mask;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [P-1:0]          wr_lane_mask;
    logic                  busy;
    logic                  done;
`ifdef LLR_FG_SCHED_PERF_CNT_EN
    logic [15:0]           cyc_cnt;
    logic [15:0]           stall_cnt;
`endif

    modport master (
        output start, op_g, node_log_pairs, rd_base, wr_base, stall,
        input  rd_en, rd_addr, pe_valid, pe_op_g, pe_lane_mask,
        input  wr_en, wr_addr, wr_lane_mask, busy, done
`ifdef LLR_FG_SCHED_PERF_CNT_EN
        , input cyc_cnt, stall_cnt
`endif
    );

    modport slave (
        input  start, op_g, node_log_pairs, rd_base, wr_base, stall,
        output rd_en, rd_addr, pe_valid, pe_op_g, pe_lane_mask,
        output wr_en, wr_addr, wr_lane_mask, busy, done
`ifdef LLR_FG_SCHED_PERF_CNT_EN
        , output cyc_cnt, stall_cnt
`endif
    );

endinterface

// File: rtl/llr_sched_addr_gen.sv
// rtl/llr_sched_addr_gen.sv - beat counter, read/write address and lane-mask generation
module llr_sched_addr_gen
    import polar_dec_pkg::*;
#(
    parameter int P          = 4,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [3:0]            node_log_pairs,
    input  logic [ADDR_WIDTH-1:0] rd_base,
    input  logic [ADDR_WIDTH-1:0] wr_base,
    input  logic                  advance,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [P-1:0]          lane_mask,
    output logic                  last_beat
);
    localparam int LOG_P = (P > 1) ? $clog2(P) : 0;

    logic [ADDR_WIDTH-1:0] rd_base_q;
    logic [ADDR_WIDTH-1:0] wr_base_q;
    logic [3:0]            log_q;
    logic [BEAT_W-1:0]     idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_base_q <= '0;
            wr_base_q <= '0;
            log_q     <= '0;
            idx       <= '0;
        end else if (load) begin
            rd_base_q <= rd_base;
            wr_base_q <= wr_base;
            log_q     <= node_log_pairs;
            idx       <= '0;
        end else if (advance) begin
            idx <= last_beat ? '0 : idx + BEAT_W'(1);
        end
    end

    assign last_beat = (idx == last_beat_idx(log_q, LOG_P));
    // Address sums are ADDR_WIDTH wide so they wrap around the LLR memory.
    assign rd_addr   = rd_base_q + ADDR_WIDTH'(idx);
    assign wr_addr   = wr_base_q + ADDR_WIDTH'(idx);

    always_comb begin
        lane_mask = '0;
        for (int i = 0; i < P; i++) begin
            lane_mask[i] = (int'(log_q) >= LOG_P) || (i < (1 << log_q));
        end
    end

endmodule

// File: rtl/llr_fg_sched.sv
// rtl/llr_fg_sched.sv - f/g pass scheduler: issue FSM plus PE/write delay pipeline; LLR_FG_SCHED_PERF_CNT_EN adds counters
module llr_fg_sched
    import polar_dec_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int P          = 4,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    llr_fg_sched_if.slave bus
);
    if (P < 1 || P > 16 || (P & (P - 1)) != 0 || DATA_WIDTH < 1) begin : g_bad_param
        $error("llr_fg_sched: P must be a power of two in 1..16 and DATA_WIDTH positive");
    end

    sched_state_e          state;
    op_e                   op_q;
    logic                  load;
    logic                  issue;
    logic                  last_beat;
    logic [ADDR_WIDTH-1:0] gen_rd_addr;
    logic [ADDR_WIDTH-1:0] gen_wr_addr;
    logic [ADDR_WIDTH-1:0] wa_d1;
    logic [P-1:0]          gen_mask;

    assign load         = (state == IDLE) && bus.start;
    assign issue        = (state == ISSUE) && !bus.stall;
    assign bus.rd_en    = issue;
    assign bus.rd_addr  = gen_rd_addr;
    assign bus.busy     = (state != IDLE);
    assign bus.done     = (state == DONE);

    llr_sched_addr_gen #(
        .P          (P),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_gen (
        .clk            (clk),
        .rst            (rst),
        .load           (load),
        .node_log_pairs (bus.node_log_pairs),
        .rd_base        (bus.rd_base),
        .wr_base        (bus.wr_base),
        .advance        (issue),
        .rd_addr        (gen_rd_addr),
        .wr_addr        (gen_wr_addr),
        .lane_mask      (gen_mask),
        .last_beat      (last_beat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            op_q             <= OP_F;
            bus.pe_valid     <= 1'b0;
            bus.pe_op_g      <= 1'b0;
            bus.pe_lane_mask <= '0;
            wa_d1            <= '0;
            bus.wr_en        <= 1'b0;
            bus.wr_addr      <= '0;
            bus.wr_lane_mask <= '0;
        end else begin
            // Idle pipeline slots carry zeros so masks and addresses read 0 between beats.
            bus.pe_valid     <= issue;
            bus.pe_op_g      <= issue && (op_q == OP_G);
            bus.pe_lane_mask <= issue ? gen_mask : '0;
            wa_d1            <= issue ? gen_wr_addr : '0;
            bus.wr_en        <= bus.pe_valid;
            bus.wr_addr      <= wa_d1;
            bus.wr_lane_mask <= bus.pe_lane_mask;

            case (state)
                IDLE: begin
                    if (bus.start) begin
                        op_q  <= op_e'(bus.op_g);
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (issue && last_beat) state <= DRAIN;
                end
                DRAIN: begin
                    if (bus.wr_en && !bus.pe_valid) state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef LLR_FG_SCHED_PERF_CNT_EN
    logic [15:0] cyc_q;
    logic [15:0] stall_q;

    always_ff @(posedge clk) begin
        if (rst || load) begin
            cyc_q   <= '0;
            stall_q <= '0;
        end else begin
            if (state != IDLE && cyc_q != 16'hFFFF) cyc_q <= cyc_q + 16'd1;
            if (state == ISSUE && bus.stall && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
        end
    end

    assign bus.cyc_cnt   = cyc_q;
    assign bus.stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_llr_fg_sched.sv
// tb/tb_llr_fg_sched.sv - table-driven self-checking bench for llr_fg_sched
module tb_llr_fg_sched;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    llr_fg_sched_if #(.P(4), .ADDR_WIDTH(10)) bus ();

    llr_fg_sched #(.DATA_WIDTH(8), .P(4), .ADDR_WIDTH(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       op_g;
        logic [3:0] logp;
        logic [9:0] rd_base;
        logic [9:0] wr_base;
        int         stall_at;
        int         stall_len;
        int         re1;
        int         re2;
        int         beats;
        logic [3:0] mask;
        int         lat;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, " ctrl"}, 32'({bus.busy, bus.done, bus.rd_en, bus.pe_valid, bus.pe_op_g, bus.wr_en}), 32'h0);
        check({tag, " addr"}, 32'({bus.rd_addr, bus.wr_addr}), 32'h0);
        check({tag, " mask"}, 32'({bus.pe_lane_mask, bus.wr_lane_mask}), 32'h0);
    endtask

    task automatic run(input vec_t v, input string tag);
        int   nrd = 0, npe = 0, nwr = 0, ndone = 0, done_cyc = -1;
        logic rd_ok = 1'b1, pe_ok = 1'b1, wr_ok = 1'b1, busy_ok = 1'b1;
        @(negedge clk);
        bus.op_g           = v.op_g;
        bus.node_log_pairs = v.logp;
        bus.rd_base        = v.rd_base;
        bus.wr_base        = v.wr_base;
        bus.stall          = 1'b0;
        bus.start          = 1'b1;
        for (int k = 1; k <= v.lat + 3; k++) begin
            @(negedge clk);
            bus.start = (k == v.re1 || k == v.re2);
            if (bus.start) begin
                bus.op_g           = ~v.op_g;
                bus.node_log_pairs = 4'd1;
                bus.rd_base        = 10'h000;
                bus.wr_base        = 10'h300;
            end
            bus.stall = (k >= v.stall_at && k < v.stall_at + v.stall_len);
            #1;
            if (bus.busy !== (k <= v.lat)) busy_ok = 1'b0;
            if (bus.rd_en === 1'b1) begin
                if (bus.rd_addr !== v.rd_base + 10'(nrd)) rd_ok = 1'b0;
                nrd++;
            end
            if (bus.pe_valid === 1'b1) begin
                if (bus.pe_op_g !== v.op_g || bus.pe_lane_mask !== v.mask) pe_ok = 1'b0;
                npe++;
            end
            if (bus.wr_en === 1'b1) begin
                if (bus.wr_addr !== v.wr_base + 10'(nwr) || bus.wr_lane_mask !== v.mask) wr_ok = 1'b0;
                nwr++;
            end
            if (bus.done === 1'b1) begin
                ndone++;
                if (done_cyc < 0) done_cyc = k;
            end
        end
        bus.start = 1'b0;
        bus.stall = 1'b0;
        check({tag, " rd_addr seq"}, 32'(rd_ok), 32'd1);
        check({tag, " pe op/mask"}, 32'(pe_ok), 32'd1);
        check({tag, " wr_addr/mask seq"}, 32'(wr_ok), 32'd1);
        check({tag, " busy window"}, 32'(busy_ok), 32'd1);
        check({tag, " rd beats"}, 32'(nrd), 32'(v.beats));
        check({tag, " pe beats"}, 32'(npe), 32'(v.beats));
        check({tag, " wr beats"}, 32'(nwr), 32'(v.beats));
        check({tag, " done pulses"}, 32'(ndone), 32'd1);
        check({tag, " done latency"}, 32'(done_cyc), 32'(v.lat));
`ifdef LLR_FG_SCHED_PERF_CNT_EN
        check({tag, " cyc_cnt"}, 32'(bus.cyc_cnt), 32'(v.lat));
        check({tag, " stall_cnt"}, 32'(bus.stall_cnt), 32'(v.stall_len));
`endif
    endtask

    initial begin
        int nwr_after, ndone_after;
        vecs[0] = '{1'b0, 4'd4, 10'h010, 10'h040, 0, 0, -1, -1, 4, 4'hF, 7};
        vecs[1] = '{1'b1, 4'd1, 10'h020, 10'h080, 0, 0, -1, -1, 1, 4'h3, 4};
        vecs[2] = '{1'b0, 4'd0, 10'h005, 10'h006, 0, 0, -1, -1, 1, 4'h1, 4};
        vecs[3] = '{1'b1, 4'd2, 10'h0A0, 10'h0B0, 0, 0, -1, -1, 1, 4'hF, 4};
        vecs[4] = '{1'b0, 4'd3, 10'h111, 10'h222, 0, 0, -1, -1, 2, 4'hF, 5};
        vecs[5] = '{1'b1, 4'd4, 10'h3FE, 10'h3FF, 0, 0, -1, -1, 4, 4'hF, 7};
        vecs[6] = '{1'b0, 4'd4, 10'h050, 10'h060, 2, 2, -1, -1, 4, 4'hF, 9};
        vecs[7] = '{1'b1, 4'd4, 10'h100, 10'h200, 0, 0, 2, 7, 4, 4'hF, 7};
        vecs[8] = '{1'b0, 4'd5, 10'h0C0, 10'h1C0, 0, 0, -1, -1, 8, 4'hF, 11};

        rst                = 1'b1;
        bus.start          = 1'b0;
        bus.op_g           = 1'b0;
        bus.node_log_pairs = 4'd0;
        bus.rd_base        = '0;
        bus.wr_base        = '0;
        bus.stall          = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_quiet("reset");
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            run(vecs[i], $sformatf("vec%0d", i));
        end

        // Abort mid-command: reset lands while the second of four beats issues.
        @(negedge clk);
        bus.op_g           = 1'b0;
        bus.node_log_pairs = 4'd4;
        bus.rd_base        = 10'h010;
        bus.wr_base        = 10'h040;
        bus.start          = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort rd_en at beat 2", 32'(bus.rd_en), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_quiet("abort");
`ifdef LLR_FG_SCHED_PERF_CNT_EN
        check("abort cyc_cnt", 32'(bus.cyc_cnt), 32'd0);
`endif
        nwr_after   = 0;
        ndone_after = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            #1;
            if (bus.wr_en === 1'b1) nwr_after++;
            if (bus.done === 1'b1) ndone_after++;
        end
        check("abort wr_en after rst", 32'(nwr_after), 32'd0);
        check("abort done after rst", 32'(ndone_after), 32'd0);

        run(vecs[0], "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
